// File: rtl/delta_liafn_scheduler_if.sv
// Current-input and spike-event streams between the delta-LIAF scheduler and its neighbours.
// The master side is the scheduler: it sinks currents and sources events.
interface delta_liafn_scheduler_if #(
  parameter int ID_W = 2
);
  logic            cur_valid;
  logic            cur_ready;
  logic [7:0]      cur_data;
  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_id;
  logic [7:0]      ev_diff;

  modport master (
    input  cur_valid, cur_data, ev_ready,
    output cur_ready, ev_valid, ev_id, ev_diff
  );

  modport slave (
    output cur_valid, cur_data, ev_ready,
    input  cur_ready, ev_valid, ev_id, ev_diff
  );
endinterface

// File: rtl/delta_liafn_scheduler.sv
// One shared leaky-integrate-and-fire datapath time-multiplexed over N_NEURONS stored states,
// emitting (id, diff) delta events into a small FIFO.
module delta_liafn_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int ID_W       = 2,
  parameter int BETA       = 128,
  parameter int DELTA_TH   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  delta_liafn_scheduler_if.master bus,
  output logic [ID_W-1:0]         cur_idx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              mon_state
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, UPDATE, EMIT, DONE} st_t;
  st_t st;

  logic [7:0] nstate [N_NEURONS];
  logic [7:0] cur_q, diff_q;
  logic       spike_q;

  logic [7:0] old, leak, new_s;
  logic [8:0] sum, diff;
  logic       spike;

  assign old   = nstate[cur_idx];
  assign leak  = 8'((16'(old) * 16'(BETA)) >> 8);
  assign sum   = {1'b0, leak} + {1'b0, cur_q};
  assign new_s = sum[8] ? 8'hff : sum[7:0];
  assign diff  = {1'b0, new_s} - {1'b0, old};
  // Signed compare so a falling state never spikes.
  assign spike = $signed(diff) >= $signed(9'(DELTA_TH));

  logic [ID_W+7:0] fmem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, pop, push, advance;

  assign full    = count == (PW+1)'(FIFO_DEPTH);
  assign pop     = bus.ev_valid && bus.ev_ready;
  // A same-cycle pop makes room, so a full FIFO still accepts the push.
  assign push    = (st == EMIT) && spike_q && (!full || pop);
  assign advance = (st == EMIT) && (!spike_q || !full || pop);

  assign bus.ev_valid          = count != '0;
  assign {bus.ev_id, bus.ev_diff} = bus.ev_valid ? fmem[rd_ptr] : '0;
  assign bus.cur_ready         = st == FETCH;
  assign mon_state             = nstate[cur_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fmem[i] <= '0;
    end else begin
      if (push) begin
        fmem[wr_ptr] <= {cur_idx, diff_q};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cur_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cur_q      <= '0;
      diff_q     <= '0;
      spike_q    <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) nstate[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (st)
        IDLE: if (start) begin
          st      <= FETCH;
          cur_idx <= '0;
          busy    <= 1'b1;
        end
        FETCH: if (bus.cur_valid) begin
          cur_q <= bus.cur_data;
          st    <= UPDATE;
        end
        UPDATE: begin
          nstate[cur_idx] <= new_s;
          spike_q         <= spike;
          diff_q          <= diff[7:0];
          st              <= EMIT;
        end
        EMIT: if (advance) begin
          if (cur_idx == ID_W'(N_NEURONS - 1)) begin
            st         <= DONE;
            frame_done <= 1'b1;
          end else begin
            cur_idx <= cur_idx + 1'b1;
            st      <= FETCH;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          cur_idx <= '0;
          st      <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delta_liafn_scheduler.sv
// Randomized bench for delta_liafn_scheduler: a per-neuron arithmetic model plus an expected-event
// queue is checked every cycle, with literal event lists pinning the model on directed frames.
module tb_delta_liafn_scheduler;
  localparam int N    = 4;
  localparam int FD   = 2;
  localparam int BETA = 128;
  localparam int TH   = 10;

  logic       clk, rst_n, start;
  logic [1:0] cur_idx;
  logic       busy, frame_done;
  logic [7:0] mon_state;

  delta_liafn_scheduler_if #(.ID_W(2)) bus();

  delta_liafn_scheduler #(
    .N_NEURONS(N), .ID_W(2), .BETA(BETA), .DELTA_TH(TH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .cur_idx(cur_idx), .busy(busy), .frame_done(frame_done), .mon_state(mon_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int frames  = 0;
  int mstate [N];
  int exp_idx = 0;
  logic [9:0] exp_q [$];
  logic [9:0] log_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] ev(input int id, input int d);
    logic [31:0] di;
    di = d;
    return {2'(id), di[7:0]};
  endfunction

  function automatic logic [3:0][7:0] all4(input logic [7:0] x);
    return {x, x, x, x};
  endfunction

  // Behavioural model: each accepted current advances that neuron's state; a spike becomes an expected event.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) mstate[i] = 0;
      exp_idx = 0;
    end else begin
      if (bus.cur_valid && bus.cur_ready) begin
        chk("fetch_idx", 32'(cur_idx), 32'(exp_idx));
        if (exp_idx < N) begin
          int old, sum, nw, d;
          chk("mon_state", 32'(mon_state), 32'(mstate[exp_idx]));
          old = mstate[exp_idx];
          sum = ((old * BETA) >> 8) + int'(bus.cur_data);
          nw  = (sum > 255) ? 255 : sum;
          d   = nw - old;
          if (d >= TH) exp_q.push_back(ev(exp_idx, d));
          mstate[exp_idx] = nw;
        end
        exp_idx++;
      end
      if (bus.ev_valid && bus.ev_ready) begin
        if (exp_q.size() == 0) chk("spurious_event", 32'({bus.ev_id, bus.ev_diff}), 32'h3ff_0000);
        else chk("event", 32'({bus.ev_id, bus.ev_diff}), 32'(exp_q.pop_front()));
        log_q.push_back({bus.ev_id, bus.ev_diff});
      end
      if (bus.ev_valid && exp_q.size() == 0 && !bus.ev_ready)
        chk("valid_without_event", 32'(bus.ev_valid), 32'd0);
      if (bus.cur_ready && !busy) chk("ready_while_idle", 32'(bus.cur_ready), 32'd0);
      if (frame_done) begin
        chk("neurons_per_frame", 32'(exp_idx), 32'(N));
        exp_idx = 0;
        frames++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; bus.cur_valid = 1'b0; bus.ev_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic run_frame(input logic [3:0][7:0] v, input bit rv, input bit rr,
                           input int stall, input bit ms);
    int acc, fr0;
    bit done;
    acc = 0; done = 0; fr0 = frames;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(posedge clk); #1;
      start         = (cyc == 0) || (ms && cyc == 6);
      bus.cur_valid = rv ? 1'($urandom % 2) : 1'b1;
      bus.cur_data  = v[(acc > 3) ? 3 : acc];
      bus.ev_ready  = (cyc < stall) ? 1'b0 : (rr ? 1'($urandom % 2) : 1'b1);
      @(negedge clk);
      if (stall > 0 && cyc == stall - 1) begin
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_ready", 32'(bus.cur_ready), 32'd0);
        chk("stall_idx", 32'(cur_idx), 32'd2);
        chk("stall_head", 32'({bus.ev_valid, bus.ev_id, bus.ev_diff}), 32'({1'b1, ev(0, 20)}));
      end
      if (bus.cur_valid && bus.cur_ready) acc++;
      if (frame_done) done = 1;
    end
    if (!done) chk("frame_timeout", 32'd0, 32'd1);
    start = 1'b0; bus.cur_valid = 1'b0; bus.ev_ready = 1'b1;
    repeat (FD + 4) @(posedge clk);
    @(negedge clk);
    chk("drained_valid", 32'(bus.ev_valid), 32'd0);
    chk("drained_model", 32'(exp_q.size()), 32'd0);
    chk("frame_done_pulses", 32'(frames), 32'(fr0 + 1));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_log(input string nm, input int n, input logic [3:0][9:0] e);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < log_q.size()) chk(nm, 32'(log_q[i]), 32'(e[i]));
    log_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $fatal(1);
  end

  initial begin
    logic [3:0][7:0] v;
    int acc;
    rst_n = 1'b0; start = 1'b0;
    bus.cur_valid = 1'b0; bus.cur_data = '0; bus.ev_ready = 1'b0;
    #12;
    chk("rst_outputs", 32'({busy, frame_done, bus.cur_ready, bus.ev_valid}), 32'd0);
    chk("rst_head", 32'({cur_idx, bus.ev_id, bus.ev_diff, mon_state}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Frames of constant 20: 0->20 (diff 20), 20->30 (diff 10 = threshold), 30->35 (diff 5).
    run_frame(all4(8'd20), 0, 0, 0, 0);
    chk_log("f1_events", 4, {ev(3, 20), ev(2, 20), ev(1, 20), ev(0, 20)});
    for (int i = 0; i < N; i++) chk("f1_state", 32'(mstate[i]), 32'd20);
    chk("f1_mon0", 32'(mon_state), 32'd20);
    run_frame(all4(8'd20), 0, 0, 0, 0);
    chk_log("f2_events", 4, {ev(3, 10), ev(2, 10), ev(1, 10), ev(0, 10)});
    for (int i = 0; i < N; i++) chk("f2_state", 32'(mstate[i]), 32'd30);
    run_frame(all4(8'd20), 0, 0, 0, 0);
    chk_log("f3_events", 0, '0);
    for (int i = 0; i < N; i++) chk("f3_state", 32'(mstate[i]), 32'd35);

    // Saturation and falling-state cases.
    do_reset();
    run_frame({8'd30, 8'd200, 8'd200, 8'd200}, 0, 0, 0, 0);
    chk_log("sat_a_events", 4, {ev(3, 30), ev(2, 200), ev(1, 200), ev(0, 200)});
    run_frame({8'd0, 8'd200, 8'd0, 8'd200}, 0, 0, 0, 0);
    chk_log("sat_b_events", 2, {20'd0, ev(2, 55), ev(0, 55)});
    chk("sat_state0", 32'(mstate[0]), 32'd255);
    chk("fall_state3", 32'(mstate[3]), 32'd15);
    chk("sat_mon0", 32'(mon_state), 32'd255);

    // Consumer stalled: FIFO fills at id2, then drains in order.
    do_reset();
    run_frame(all4(8'd20), 0, 0, 20, 0);
    chk_log("stall_events", 4, {ev(3, 20), ev(2, 20), ev(1, 20), ev(0, 20)});

    // Reset while neuron 2 is in UPDATE with two events queued.
    do_reset();
    @(posedge clk); #1;
    start = 1'b1; bus.cur_valid = 1'b1; bus.cur_data = 8'd20; bus.ev_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    acc = 0;
    for (int c = 0; c < 60 && acc < 3; c++) begin
      @(negedge clk);
      if (bus.cur_valid && bus.cur_ready) acc++;
    end
    chk("mid_rst_accepts", 32'(acc), 32'd3);
    chk("mid_rst_queued", 32'(bus.ev_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'({busy, frame_done, bus.cur_ready, bus.ev_valid}), 32'd0);
    chk("mid_rst_head", 32'({cur_idx, bus.ev_id, bus.ev_diff, mon_state}), 32'd0);
    bus.cur_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    log_q.delete();
    run_frame(all4(8'd20), 0, 0, 0, 0);
    chk_log("post_rst_events", 4, {ev(3, 20), ev(2, 20), ev(1, 20), ev(0, 20)});

    // Random currents, random handshakes, stray start pulses.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < N; i++)
        v[i] = ($urandom % 2) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      run_frame(v, 1, 1, 0, f[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
